// File: rtl/bin_to_seg4.sv
// Sequential double-dabble: 14-bit binary to four active-high 7-segment digits, 15 clocks start->done.
// No backpressure: start is ignored while busy; digit outputs hold until the next ENCODE edge.
module bin_to_seg4 #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [6:0]       digit_0,
  output logic [6:0]       digit_1,
  output logic [6:0]       digit_2,
  output logic [6:0]       digit_3
);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [3:0]       CNT_INIT = 4'(WIDTH - 1);
  localparam logic [6:0]       SEG_DASH = 7'h40;
  localparam logic [6:0]       SEG_BLNK = 7'h00;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q;
  logic [15:0]       bcd_q;
  logic [15:0]       bcd_adj;
  logic [WIDTH+15:0] shifted;
  logic [3:0]        cnt_q;
  logic              blz_q;
  logic              ovf_q;
  logic              done_q;
  logic [6:0]        dig0_q, dig1_q, dig2_q, dig3_q;
  logic [6:0]        enc0, enc1, enc2, enc3;
  logic              z1, z2, z3;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd0) state_d = ENCODE;
      ENCODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    digit_0 = dig0_q;
    digit_1 = dig1_q;
    digit_2 = dig2_q;
    digit_3 = dig3_q;
  end

  // Add-3 correction is applied before the shift, so the shift sees corrected nibbles
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Leading-zero blanking cascades down from the thousands digit; units is never blanked
  always_comb begin
    z3 = (bcd_q[15:12] == 4'd0);
    z2 = z3 && (bcd_q[11:8] == 4'd0);
    z1 = z2 && (bcd_q[7:4] == 4'd0);
    enc0 = seg7(bcd_q[3:0]);
    enc1 = (blz_q && z1) ? SEG_BLNK : seg7(bcd_q[7:4]);
    enc2 = (blz_q && z2) ? SEG_BLNK : seg7(bcd_q[11:8]);
    enc3 = (blz_q && z3) ? SEG_BLNK : seg7(bcd_q[15:12]);
    if (ovf_q) begin
      enc0 = SEG_DASH;
      enc1 = SEG_DASH;
      enc2 = SEG_DASH;
      enc3 = SEG_DASH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      blz_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      dig0_q <= SEG_BLNK;
      dig1_q <= SEG_BLNK;
      dig2_q <= SEG_BLNK;
      dig3_q <= SEG_BLNK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= value;
            blz_q <= blank_lz;
            ovf_q <= (value > MAX_V);
            bcd_q <= '0;
            cnt_q <= CNT_INIT;
          end
        end
        SHIFT: begin
          bcd_q <= shifted[WIDTH+15:WIDTH];
          bin_q <= shifted[WIDTH-1:0];
          cnt_q <= cnt_q - 4'd1;
        end
        ENCODE: begin
          dig0_q <= enc0;
          dig1_q <= enc1;
          dig2_q <= enc2;
          dig3_q <= enc3;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_seg4.sv
// Self-checking bench for bin_to_seg4: directed cases plus randomized conversions vs. arithmetic model.
module tb_bin_to_seg4;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] value;
  logic        blank_lz;
  logic        busy, done;
  logic [6:0]  digit_0, digit_1, digit_2, digit_3;
  logic [27:0] digs;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  bin_to_seg4 dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .blank_lz(blank_lz),
    .busy(busy), .done(done),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3)
  );

  assign digs = {digit_3, digit_2, digit_1, digit_0};

  // Reference: decimal digits by division, blanking by magnitude of the value
  function automatic logic [27:0] ref_digits(input int v, input bit b);
    logic [6:0] d [4];
    int p;
    if (v > 9999) return {4{7'h40}};
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = seg_tbl[(v / p) % 10];
      p = p * 10;
    end
    if (b && v < 1000) d[3] = 7'h00;
    if (b && v < 100)  d[2] = 7'h00;
    if (b && v < 10)   d[1] = 7'h00;
    return {d[3], d[2], d[1], d[0]};
  endfunction

  // Drives one conversion and observes 20 cycles after the accepting edge (k = edges since E0)
  task automatic do_conv(input logic [13:0] v, input bit b, output logic [27:0] got,
                         output int done_at, output int busy_cnt, output int done_cnt,
                         output int early_chg);
    logic [27:0] prev;
    @(negedge clk);
    start = 1'b1; value = v; blank_lz = b;
    prev = digs;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; value = 14'($urandom); blank_lz = 1'($urandom);
    busy_cnt = 0; done_cnt = 0; done_at = -1; early_chg = 0; got = 'x;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (k < 15 && digs !== prev) early_chg++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          got = digs;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; value = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (digs !== 28'h0) begin errors++; $display("FAIL reset_digits got=%h exp=0", digs); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [27:0] got; int da, bc, dc, ec;
    do_conv(14'd1234, 1'b0, got, da, bc, dc, ec);
    checks++; if (da !== 15) begin errors++; $display("FAIL basic_latency got=%0d exp=15", da); end
    checks++; if (bc !== 15) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=15", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dc); end
    checks++; if (got !== {7'h06, 7'h5B, 7'h4F, 7'h66}) begin errors++; $display("FAIL basic_digits got=%h exp=%h", got, {7'h06, 7'h5B, 7'h4F, 7'h66}); end
    checks++; if (digs !== got) begin errors++; $display("FAIL basic_hold got=%h exp=%h", digs, got); end
  endtask

  task automatic test_blanking;
    int          vals [4] = '{7, 7, 0, 1005};
    bit          blz  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [27:0] exp  [4] = '{{7'h00, 7'h00, 7'h00, 7'h07}, {7'h3F, 7'h3F, 7'h3F, 7'h07},
                              {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h06, 7'h3F, 7'h3F, 7'h6D}};
    logic [27:0] got; int da, bc, dc, ec;
    for (int i = 0; i < 4; i++) begin
      do_conv(14'(vals[i]), blz[i], got, da, bc, dc, ec);
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL blank_%0d_%0d got=%h exp=%h", vals[i], blz[i], got, exp[i]); end
    end
  endtask

  task automatic test_boundary;
    int          vals [4] = '{9999, 10000, 16383, 10000};
    bit          blz  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [27:0] exp  [4] = '{{4{7'h6F}}, {4{7'h40}}, {4{7'h40}}, {4{7'h40}}};
    logic [27:0] got; int da, bc, dc, ec;
    for (int i = 0; i < 4; i++) begin
      do_conv(14'(vals[i]), blz[i], got, da, bc, dc, ec);
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL boundary_%0d got=%h exp=%h", vals[i], got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [27:0] got1, got2; int da1, dc1, da2, dc2;
    @(negedge clk);
    start = 1'b1; value = 14'd1234; blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    da1 = -1; dc1 = 0; got1 = 'x;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin dc1++; if (da1 < 0) begin da1 = k; got1 = digs; end end
      if (k == 5) begin start = 1'b1; value = 14'd42; blank_lz = 1'b1; end
      else if (k == 6) start = 1'b0;
      else if (k == 15) begin start = 1'b1; value = 14'd42; blank_lz = 1'b1; end
    end
    checks++; if (dc1 !== 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", dc1); end
    checks++; if (da1 !== 15) begin errors++; $display("FAIL ignore_latency got=%0d exp=15", da1); end
    checks++; if (got1 !== {7'h06, 7'h5B, 7'h4F, 7'h66}) begin errors++; $display("FAIL ignore_digits got=%h exp=%h", got1, {7'h06, 7'h5B, 7'h4F, 7'h66}); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    da2 = -1; dc2 = 0; got2 = 'x;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin dc2++; if (da2 < 0) begin da2 = k; got2 = digs; end end
    end
    checks++; if (da2 !== 15) begin errors++; $display("FAIL b2b_latency got=%0d exp=15", da2); end
    checks++; if (dc2 !== 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", dc2); end
    checks++; if (got2 !== {7'h00, 7'h00, 7'h66, 7'h5B}) begin errors++; $display("FAIL b2b_digits got=%h exp=%h", got2, {7'h00, 7'h00, 7'h66, 7'h5B}); end
  endtask

  task automatic test_reset_abort;
    logic [27:0] got; int da, bc, dc, ec, spurious;
    @(negedge clk);
    start = 1'b1; value = 14'd5678; blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (digs !== 28'h0) begin errors++; $display("FAIL abort_digits got=%h exp=0", digs); end
    @(negedge clk);
    reset = 1'b1;
    spurious = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_spurious got=%0d exp=0", spurious); end
    do_conv(14'd5678, 1'b0, got, da, bc, dc, ec);
    checks++; if (got !== {7'h6D, 7'h7D, 7'h07, 7'h7F}) begin errors++; $display("FAIL abort_restart got=%h exp=%h", got, {7'h6D, 7'h7D, 7'h07, 7'h7F}); end
    checks++; if (da !== 15) begin errors++; $display("FAIL abort_restart_latency got=%0d exp=15", da); end
  endtask

  task automatic test_random;
    logic [27:0] got, exp; int da, bc, dc, ec, v; bit b;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      v = (n % 4 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
      b = 1'($urandom);
      exp = ref_digits(v, b);
      do_conv(14'(v), b, got, da, bc, dc, ec);
      checks++; if (got !== exp) begin errors++; $display("FAIL rand_digits v=%0d b=%0d got=%h exp=%h", v, b, got, exp); end
      checks++; if (da !== 15 || dc !== 1 || bc !== 15) begin errors++; $display("FAIL rand_timing v=%0d done_at=%0d pulses=%0d busy=%0d exp=15/1/15", v, da, dc, bc); end
      checks++; if (ec !== 0) begin errors++; $display("FAIL rand_early_change v=%0d got=%0d exp=0", v, ec); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_blanking;
    test_boundary;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
